// File: rtl/uart_apb_pkg.sv
// Shared constants, register map and FSM encodings for the UART/APB bridge.
package uart_apb_pkg;

  localparam int unsigned CLKS_PER_BIT = 1042;
  localparam int unsigned DATA_BITS    = 32;
  localparam int unsigned BIT_W        = $clog2(DATA_BITS);

  localparam logic [31:0] ADDR_TX   = 32'd0;
  localparam logic [31:0] ADDR_RX   = 32'd1;
  localparam logic [31:0] ADDR_STAT = 32'd2;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_DONE
  } tx_state_e;

endpackage

// File: rtl/uart_rx_engine.sv
// Serial receiver: rx synchronizer, mid-bit sampling FSM and the received-word register.
module uart_rx_engine
  import uart_apb_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = uart_apb_pkg::CLKS_PER_BIT
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  input  logic                 i_rd_clr,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;

  logic [1:0]           r_sync;
  logic                 r_prev;
  rx_state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [BIT_W-1:0]     r_bit, w_bit_nxt;
  logic [DATA_BITS-1:0] r_shift, r_rx_data;
  logic                 r_rx_valid;
  logic                 w_rx_s, w_fall, w_half_tick, w_bit_tick;
  logic                 w_shift_en, w_commit;

  assign w_rx_s      = r_sync[1];
  assign w_fall      = r_prev & ~w_rx_s;
  assign w_half_tick = (r_cnt == CNT_W'(HALF - 1));
  assign w_bit_tick  = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_bit_nxt   = r_bit;
    case (r_state)
      RX_IDLE: begin
        w_cnt_nxt = '0;
        w_bit_nxt = '0;
        if (w_fall) w_state_nxt = RX_START;
      end
      RX_START: begin
        // Still low at mid start bit means a real frame, otherwise a glitch
        if (w_half_tick) begin
          w_cnt_nxt   = '0;
          w_state_nxt = w_rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (w_bit_tick) begin
          w_cnt_nxt = '0;
          if (r_bit == BIT_W'(DATA_BITS - 1)) w_state_nxt = RX_STOP;
          else                                w_bit_nxt   = r_bit + BIT_W'(1);
        end
      end
      RX_STOP: begin
        if (w_bit_tick) w_state_nxt = RX_IDLE;
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    w_shift_en = (r_state == RX_DATA) && w_bit_tick;
    w_commit   = (r_state == RX_STOP) && w_bit_tick && w_rx_s;
  end

  // Commit wins over a same-cycle read clear so a fresh word is never lost
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync     <= 2'b11;
      r_prev     <= 1'b1;
      r_shift    <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_rx};
      r_prev <= w_rx_s;
      if (w_shift_en) r_shift[r_bit] <= w_rx_s;
      if (w_commit) begin
        r_rx_data  <= r_shift;
        r_rx_valid <= 1'b1;
      end else if (i_rd_clr) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;

endmodule

// File: rtl/uart_apb_bridge.sv
// 32-bit-word UART behind an APB-style register port: TX engine, register map and RX engine instance.
module uart_apb_bridge
  import uart_apb_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = uart_apb_pkg::CLKS_PER_BIT
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [31:0] apb_write_paddr,
  input  logic [31:0] apb_read_paddr,
  input  logic [31:0] apb_write_data,
  input  logic        READ_WRITE,
  input  logic        transfer,
  input  logic        PSEL1,
  output logic [31:0] apb_read_data_outu,
  input  logic        rx,
  output logic        tx,
  output logic        txDone,
  output logic        TxBusy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  logic                 w_access, w_rd, w_wr_go, w_rd_clr;
  logic [DATA_BITS-1:0] r_tx_data, r_rdata, w_rx_data;
  logic                 w_rx_valid;
  tx_state_e            r_tx_state, w_tx_state_nxt;
  logic [CNT_W-1:0]     r_tx_cnt, w_tx_cnt_nxt;
  logic [BIT_W-1:0]     r_tx_bit, w_tx_bit_nxt;
  logic                 r_tx, r_busy, r_done;
  logic                 w_tx_nxt, w_busy_nxt, w_done_nxt;
  logic                 w_bit_tick;

  assign w_access   = PSEL1 & transfer;
  assign w_rd       = w_access & READ_WRITE;
  assign w_wr_go    = w_access & ~READ_WRITE & (apb_write_paddr == ADDR_TX) &
                      (r_tx_state == TX_IDLE);
  assign w_rd_clr   = w_rd & (apb_read_paddr == ADDR_RX);
  assign w_bit_tick = (r_tx_cnt == CNT_W'(CLKS_PER_BIT - 1));

  uart_rx_engine #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .i_clk      (PCLK),
    .i_rst      (PRESETn),
    .i_rx       (rx),
    .i_rd_clr   (w_rd_clr),
    .o_rx_data  (w_rx_data),
    .o_rx_valid (w_rx_valid)
  );

  // Register map: write latch and registered read mux
  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      r_tx_data <= '0;
      r_rdata   <= '0;
    end else begin
      if (w_wr_go) r_tx_data <= apb_write_data;
      if (w_rd) begin
        case (apb_read_paddr)
          ADDR_TX:   r_rdata <= r_tx_data;
          ADDR_RX:   r_rdata <= w_rx_data;
          ADDR_STAT: r_rdata <= {30'b0, w_rx_valid, r_busy};
          default:   r_rdata <= '0;
        endcase
      end
    end
  end

  // TX state register; line outputs are registered from the next state
  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt + CNT_W'(1);
    w_tx_bit_nxt   = r_tx_bit;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_cnt_nxt = '0;
        w_tx_bit_nxt = '0;
        if (w_wr_go) w_tx_state_nxt = TX_START;
      end
      TX_START: begin
        if (w_bit_tick) begin
          w_tx_cnt_nxt   = '0;
          w_tx_state_nxt = TX_DATA;
        end
      end
      TX_DATA: begin
        if (w_bit_tick) begin
          w_tx_cnt_nxt = '0;
          if (r_tx_bit == BIT_W'(DATA_BITS - 1)) w_tx_state_nxt = TX_STOP;
          else                                   w_tx_bit_nxt   = r_tx_bit + BIT_W'(1);
        end
      end
      TX_STOP: begin
        if (w_bit_tick) begin
          w_tx_cnt_nxt   = '0;
          w_tx_state_nxt = TX_DONE;
        end
      end
      TX_DONE: begin
        w_tx_cnt_nxt   = '0;
        w_tx_state_nxt = TX_IDLE;
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    w_tx_nxt   = 1'b1;
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    case (w_tx_state_nxt)
      TX_START: begin
        w_tx_nxt   = 1'b0;
        w_busy_nxt = 1'b1;
      end
      TX_DATA: begin
        w_tx_nxt   = r_tx_data[w_tx_bit_nxt];
        w_busy_nxt = 1'b1;
      end
      TX_STOP: w_busy_nxt = 1'b1;
      TX_DONE: w_done_nxt = 1'b1;
      default: ;
    endcase
  end

  assign apb_read_data_outu = r_rdata;
  assign tx                 = r_tx;
  assign TxBusy             = r_busy;
  assign txDone             = r_done;

endmodule

// File: tb/tb_uart_apb_bridge.sv
// Directed-plus-random bench for uart_apb_bridge against a word-level model of the register map and serial frames.
module tb_uart_apb_bridge;

  localparam int unsigned CPB    = 16;
  localparam int unsigned FRAME  = 34;
  localparam int unsigned GLITCH = 3;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [31:0] apb_write_paddr, apb_read_paddr, apb_write_data;
  logic        READ_WRITE, transfer, PSEL1;
  logic [31:0] apb_read_data_outu;
  logic        rx, tx, txDone, TxBusy;

  int n_cmp = 0;
  int n_err = 0;

  // Word-level model of the visible register state
  logic [31:0] exp_tx    = '0;
  logic [31:0] exp_rx    = '0;
  logic        exp_valid = 1'b0;
  logic [31:0] last_rd   = '0;

  uart_apb_bridge #(.CLKS_PER_BIT(CPB)) dut (
    .PCLK               (PCLK),
    .PRESETn            (PRESETn),
    .apb_write_paddr    (apb_write_paddr),
    .apb_read_paddr     (apb_read_paddr),
    .apb_write_data     (apb_write_data),
    .READ_WRITE         (READ_WRITE),
    .transfer           (transfer),
    .PSEL1              (PSEL1),
    .apb_read_data_outu (apb_read_data_outu),
    .rx                 (rx),
    .tx                 (tx),
    .txDone             (txDone),
    .TxBusy             (TxBusy)
  );

  always #5 PCLK = ~PCLK;

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    PSEL1      = 1'b0;
    transfer   = 1'b0;
    READ_WRITE = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    PSEL1 = 1'b1; transfer = 1'b1; READ_WRITE = 1'b0;
    apb_write_paddr = a; apb_write_data = d;
    step();
    idle_bus();
  endtask

  // Read one register and compare against the model; reading RX consumes rx_valid
  task automatic check_read(input string tag, input logic [31:0] a);
    logic [31:0] exp;
    case (a)
      32'd0:   exp = exp_tx;
      32'd1:   exp = exp_rx;
      32'd2:   exp = {30'b0, exp_valid, 1'b0};
      default: exp = '0;
    endcase
    PSEL1 = 1'b1; transfer = 1'b1; READ_WRITE = 1'b1; apb_read_paddr = a;
    step();
    idle_bus();
    check(tag, apb_read_data_outu, exp);
    last_rd = exp;
    if (a == 32'd1) exp_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [FRAME-1:0] frame, input int n);
    for (int i = 0; i < n; i++) begin
      rx = frame[i];
      repeat (CPB) step();
    end
  endtask

  task automatic rx_frame(input logic [31:0] word, input logic stop);
    send_bits({stop, word, 1'b0}, FRAME);
    rx = 1'b1;
    repeat (4) step();
    if (stop) begin
      exp_rx    = word;
      exp_valid = 1'b1;
    end
  endtask

  // Launch a transmission, attempt an overlapping write mid-frame, check every line cycle
  task automatic tx_frame(input logic [31:0] word, input logic [31:0] intruder);
    logic [FRAME-1:0] frame;
    frame = {1'b1, word, 1'b0};
    bus_write(32'd0, word);
    exp_tx = word;
    for (int k = 0; k < int'(FRAME * CPB); k++) begin
      check("tx_line", 32'(tx), 32'(frame[k / CPB]));
      check("tx_busy_done", {30'b0, TxBusy, txDone}, 32'h2);
      if (k == int'(5 * CPB)) begin
        PSEL1 = 1'b1; transfer = 1'b1; READ_WRITE = 1'b0;
        apb_write_paddr = 32'd0; apb_write_data = intruder;
      end else begin
        idle_bus();
      end
      step();
    end
    idle_bus();
    check("tx_done_pulse", {29'b0, TxBusy, txDone, tx}, 32'h3);
    step();
    check("tx_done_cleared", {29'b0, TxBusy, txDone, tx}, 32'h1);
    check_read("tx_reg_after", 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    rx = 1'b1;
    apb_write_paddr = '0; apb_read_paddr = '0; apb_write_data = '0;
    idle_bus();
    PRESETn = 1'b1;
    repeat (2) step();
    PRESETn = 1'b0;

    check("reset_lines", {29'b0, tx, TxBusy, txDone}, 32'h4);
    check("reset_rdata", apb_read_data_outu, 32'h0);
    check_read("reset_stat", 32'd2);
    check_read("reset_tx", 32'd0);
    check_read("reset_rx", 32'd1);

    rx_frame(32'hFFFF_FFFF, 1'b1);
    check_read("ones_stat_before", 32'd2);
    check_read("ones_data", 32'd1);
    check_read("ones_stat_after", 32'd2);

    rx_frame(32'hA5A5_3C0F, 1'b1);
    check_read("pattern_data", 32'd1);
    repeat (5) step();
    check("rdata_hold", apb_read_data_outu, last_rd);
    check_read("bad_addr_7", 32'd7);
    check_read("bad_addr_top", 32'h8000_0001);

    for (int i = 0; i < 3; i++) begin
      rx_frame($urandom, 1'b1);
      check_read("rand_stat", 32'd2);
      check_read("rand_data", 32'd1);
    end

    rx_frame($urandom, 1'b0);
    repeat (CPB) step();
    check_read("framing_stat", 32'd2);
    check_read("framing_data", 32'd1);

    rx = 1'b0;
    repeat (GLITCH) step();
    rx = 1'b1;
    repeat (2 * CPB) step();
    check_read("glitch_stat", 32'd2);
    check_read("glitch_data", 32'd1);

    tx_frame(32'h1234_5678, 32'hDEAD_BEEF);
    tx_frame($urandom, $urandom);

    bus_write(32'd5, $urandom);
    step();
    check("odd_addr_busy", 32'(TxBusy), 32'h0);
    check_read("odd_addr_tx", 32'd0);

    // Abort an in-flight TX and RX frame with reset
    w = $urandom;
    bus_write(32'd0, $urandom);
    send_bits({1'b1, w, 1'b0}, 10);
    PRESETn = 1'b1;
    step();
    PRESETn = 1'b0;
    rx = 1'b1;
    exp_tx = '0; exp_rx = '0; exp_valid = 1'b0;
    check("midreset_lines", {29'b0, tx, TxBusy, txDone}, 32'h4);
    check("midreset_rdata", apb_read_data_outu, 32'h0);
    repeat (2 * CPB) step();
    check("midreset_quiet", {29'b0, tx, TxBusy, txDone}, 32'h4);
    check_read("midreset_tx", 32'd0);
    check_read("midreset_rx", 32'd1);
    check_read("midreset_stat", 32'd2);

    rx_frame($urandom, 1'b1);
    check_read("post_reset_stat", 32'd2);
    check_read("post_reset_data", 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
